// File: rtl/alu_pkg.sv
// Shared ALU op codes, mul/div FSM state type and op classification helper.
package alu_pkg;

    localparam logic [4:0] ALU_AND   = 5'h00;
    localparam logic [4:0] ALU_OR    = 5'h01;
    localparam logic [4:0] ALU_ADD   = 5'h02;
    localparam logic [4:0] ALU_SUB   = 5'h06;
    localparam logic [4:0] ALU_SLT   = 5'h07;
    localparam logic [4:0] ALU_XOR   = 5'h08;
    localparam logic [4:0] ALU_SLTU  = 5'h09;
    localparam logic [4:0] ALU_NOR   = 5'h0C;
    localparam logic [4:0] ALU_MULT  = 5'h10;
    localparam logic [4:0] ALU_MULTU = 5'h11;
    localparam logic [4:0] ALU_DIV   = 5'h12;
    localparam logic [4:0] ALU_DIVU  = 5'h13;
    localparam logic [4:0] ALU_MFHI  = 5'h14;
    localparam logic [4:0] ALU_MFLO  = 5'h15;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] ctl);
        return (ctl == ALU_MULT) || (ctl == ALU_MULTU) ||
               (ctl == ALU_DIV)  || (ctl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide on
// operand magnitudes, with a final sign-fix cycle that writes HI/LO.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic             mul_mode;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_mag_r;
    logic [WIDTH-1:0] hi_acc;
    logic [WIDTH-1:0] lo_acc;

    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_signed = (op == ALU_MULT) || (op == ALU_DIV);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        addend    = lo_acc[0] ? b_mag_r : {WIDTH{1'b0}};
        mul_sum   = {1'b0, hi_acc} + {1'b0, addend};
        div_shift = {hi_acc, lo_acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_r};
        prod      = {hi_acc, lo_acc};
        fix_hi    = hi_acc;
        fix_lo    = lo_acc;
        if (mul_mode) begin
            {fix_hi, fix_lo} = neg_q ? -prod : prod;
        end else if (b_zero) begin
            fix_hi = a_lat;
            fix_lo = {WIDTH{1'b1}};
        end else begin
            fix_lo = neg_q ? -lo_acc : lo_acc;
            fix_hi = neg_r ? -hi_acc : hi_acc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            mul_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            a_lat    <= '0;
            b_mag_r  <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_muldiv(op)) begin
                        state    <= RUN;
                        count    <= '0;
                        mul_mode <= (op == ALU_MULT) || (op == ALU_MULTU);
                        neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op_signed && a[WIDTH-1];
                        b_zero   <= (b == '0);
                        a_lat    <= a;
                        b_mag_r  <= b_mag;
                        hi_acc   <= '0;
                        lo_acc   <= a_mag;
                    end
                end
                RUN: begin
                    if (mul_mode) begin
                        hi_acc <= mul_sum[WIDTH:1];
                        lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
                    end else begin
                        // Restore (keep the shifted value) when the trial subtract underflows.
                        hi_acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        lo_acc <= {lo_acc[WIDTH-2:0], ~div_diff[WIDTH]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational op mux, MFHI/MFLO readback and Zero flag,
// wrapped around the iterative multiply/divide engine.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (ALUctl),
        .a     (A),
        .b     (B),
        .busy  (busy),
        .done  (done),
        .hi    (HI),
        .lo    (LO)
    );

    always_comb begin
        ALUOut = '0;
        case (ALUctl)
            ALU_AND:  ALUOut = A & B;
            ALU_OR:   ALUOut = A | B;
            ALU_ADD:  ALUOut = A + B;
            ALU_SUB:  ALUOut = A - B;
            ALU_SLT:  ALUOut = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_XOR:  ALUOut = A ^ B;
            ALU_SLTU: ALUOut = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_NOR:  ALUOut = ~(A | B);
            ALU_MFHI: ALUOut = HI;
            ALU_MFLO: ALUOut = LO;
            default:  ALUOut = '0;
        endcase
    end

    assign Zero = (ALUOut == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [4:0]  ctl32, ctl8;
    logic [31:0] a32, b32, out32, hi32, lo32;
    logic [7:0]  a8, b8, out8, hi8, lo8;
    logic        zero32, busy32, done32, zero8, busy8, done8;

    int checks = 0;
    int failures = 0;

    alu_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUctl(ctl32), .A(a32), .B(b32),
        .ALUOut(out32), .Zero(zero32), .busy(busy32), .done(done32), .HI(hi32), .LO(lo32)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUctl(ctl8), .A(a8), .B(b8),
        .ALUOut(out8), .Zero(zero8), .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
    );

    always #5 clk = ~clk;

    // Launches one mul/div op and waits (bounded) for done; lat counts edges after the start edge.
    task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat, output bit busy_ok);
        logic d, bz;
        if (w8) begin
            ctl8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end else begin
            ctl32 = op; a32 = a; b32 = b; start32 = 1'b1;
        end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (lat < 200) begin
            d  = w8 ? done8 : done32;
            bz = w8 ? busy8 : busy32;
            if (d) begin
                if (bz) busy_ok = 1'b0;
                break;
            end
            if (!bz) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        hi = w8 ? {24'h0, hi8} : hi32;
        lo = w8 ? {24'h0, lo8} : lo32;
    endtask

    task automatic test_reset;
        reset = 1'b1; start32 = 1'b1; ctl32 = 5'h10; a32 = 32'd5; b32 = 32'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy32); end
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done32); end
        checks++; if (hi32 !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi32); end
        checks++; if (lo32 !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo32); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        start32 = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_start_dropped got=%b exp=0", busy32); end
    endtask

    task automatic test_comb;
        logic [4:0]  ops [12] = '{5'h00, 5'h01, 5'h02, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0C, 5'h1F, 5'h10, 5'h02, 5'h06};
        logic [31:0] av  [12] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd0};
        logic [31:0] bv  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                  32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1, 32'd1};
        logic [31:0] ev  [12] = '{32'd5, 32'hFFFFFFFF, 32'd4, 32'd10, 32'd0, 32'hFFFFFFFA, 32'd1, 32'd0,
                                  32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) begin
            ctl32 = ops[i]; a32 = av[i]; b32 = bv[i];
            #1;
            checks++;
            if (out32 !== ev[i]) begin failures++; $display("FAIL comb_op%02h_%0d got=%h exp=%h", ops[i], i, out32, ev[i]); end
            checks++;
            if (zero32 !== (ev[i] == 32'h0)) begin failures++; $display("FAIL zero_op%02h_%0d got=%b exp=%b", ops[i], i, zero32, ev[i] == 32'h0); end
        end
        ctl32 = 5'h07; a32 = 32'h80000000; b32 = 32'd1; #1;
        checks++; if (out32 !== 32'd1) begin failures++; $display("FAIL slt_minneg got=%h exp=1", out32); end
        ctl32 = 5'h09; #1;
        checks++; if (out32 !== 32'd0) begin failures++; $display("FAIL sltu_minneg got=%h exp=0", out32); end
        @(posedge clk); #1;
    endtask

    task automatic test_mult_timing;
        logic [31:0] hi, lo; int lat; bit bok;
        run_op(1'b0, 5'h10, 32'hFFFFFFFA, 32'd7, hi, lo, lat, bok);
        checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL mult_busy_window got=%b exp=1", bok); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFD6) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffd6", lo); end
        @(posedge clk); #1;
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done32); end
        ctl32 = 5'h14; #1;
        checks++; if (out32 !== 32'hFFFFFFFF) begin failures++; $display("FAIL mfhi got=%h exp=ffffffff", out32); end
        ctl32 = 5'h15; #1;
        checks++; if (out32 !== 32'hFFFFFFD6) begin failures++; $display("FAIL mflo got=%h exp=ffffffd6", out32); end
    endtask

    task automatic test_muldiv32;
        logic [4:0]  ops [8] = '{5'h11, 5'h12, 5'h13, 5'h12, 5'h12, 5'h10, 5'h13, 5'h12};
        logic [31:0] av  [8] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h10, 32'd0};
        logic [31:0] eh  [8] = '{32'd1, 32'hFFFFFFFF, 32'd7, 32'd0, 32'd1, 32'd0, 32'hF, 32'hFFFFFFFB};
        logic [31:0] el  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'd1, 32'h0FFFFFFF, 32'hFFFFFFFF};
        logic [31:0] hi, lo; int lat; bit bok;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, ops[i], av[i], bv[i], hi, lo, lat, bok);
            checks++;
            if (lat !== 33) begin failures++; $display("FAIL md32_lat_%0d got=%0d exp=33", i, lat); end
            checks++;
            if (hi !== eh[i]) begin failures++; $display("FAIL md32_hi_%0d op=%02h got=%h exp=%h", i, ops[i], hi, eh[i]); end
            checks++;
            if (lo !== el[i]) begin failures++; $display("FAIL md32_lo_%0d op=%02h got=%h exp=%h", i, ops[i], lo, el[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op;
        int dones = 0;
        ctl32 = 5'h10; a32 = 32'hFFFFFFFA; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy32); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy32); end
        checks++; if (hi32 !== 32'h0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", hi32); end
        checks++; if (lo32 !== 32'h0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", lo32); end
        repeat (50) begin
            @(posedge clk); #1;
            if (done32) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_restart_ignored;
        int dones = 0;
        logic [31:0] hi = 32'hDEAD, lo = 32'hDEAD;
        ctl32 = 5'h10; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        ctl32 = 5'h11; a32 = 32'd100; b32 = 32'd100; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done32) begin dones++; hi = hi32; lo = lo32; end
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", dones); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL restart_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd15) begin failures++; $display("FAIL restart_lo got=%h exp=f", lo); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo; int lat; bit bok;
        run_op(1'b0, 5'h13, 32'd100, 32'd7, hi, lo, lat, bok);
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_first_lo got=%h exp=e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_first_hi got=%h exp=2", hi); end
        // Still in the done cycle: the next start must be accepted.
        run_op(1'b0, 5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, lat, bok);
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_second_lat got=%0d exp=33", lat); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL b2b_second_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd1) begin failures++; $display("FAIL b2b_second_lo got=%h exp=1", lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_width8;
        logic [4:0]  ops [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h12, 5'h10, 5'h12};
        logic [31:0] av  [7] = '{32'hF6, 32'hF6, 32'h9C, 32'h9C, 32'h80, 32'h80, 32'h80};
        logic [31:0] bv  [7] = '{32'h0C, 32'h0C, 32'h07, 32'h07, 32'hFF, 32'h80, 32'h00};
        logic [31:0] eh  [7] = '{32'hFF, 32'h0B, 32'hFE, 32'h02, 32'h00, 32'h40, 32'h80};
        logic [31:0] el  [7] = '{32'h88, 32'h88, 32'hF2, 32'h16, 32'h80, 32'h00, 32'hFF};
        logic [31:0] hi, lo; int lat; bit bok;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b1, ops[i], av[i], bv[i], hi, lo, lat, bok);
            checks++;
            if (lat !== 9) begin failures++; $display("FAIL w8_lat_%0d got=%0d exp=9", i, lat); end
            checks++;
            if (bok !== 1'b1) begin failures++; $display("FAIL w8_busy_%0d got=%b exp=1", i, bok); end
            checks++;
            if (hi !== eh[i]) begin failures++; $display("FAIL w8_hi_%0d op=%02h got=%h exp=%h", i, ops[i], hi, eh[i]); end
            checks++;
            if (lo !== el[i]) begin failures++; $display("FAIL w8_lo_%0d op=%02h got=%h exp=%h", i, ops[i], lo, el[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
        ctl32 = 5'h0; ctl8 = 5'h0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        test_reset();
        test_comb();
        test_mult_timing();
        test_muldiv32();
        test_reset_mid_op();
        test_restart_ignored();
        test_back_to_back();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
